deser_rx: RTL
=============

Name: deser_rx

Overview:
- Serial-in / parallel-out frame receiver.
- Receiving end of the team's parallel-load shift-register transmitter: takes one serial bit per enabled clock and reassembles N-bit words.
- Hands each completed word to downstream logic over a valid/ready handshake.
- Flags framing errors and overflow.

Parameters:
- N, 4, data bits per frame (N >= 2).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- en  input  1  bit strobe; the serial line is sampled only on cycles with en=1.
- data  input  1  serial line; idles at 1.
- ready  input  1  downstream accepts q this cycle.
- q  output  N  received word; q[0] is the first data bit received.
- valid  output  1  q holds an unconsumed word.
- busy  output  1  FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- ovf  output  1  one-cycle pulse: completed word dropped because the output was full.

Behaviour:
- Frame format on data, one bit per en cycle: start (0), then N data bits (first bit -> q[0]), then stop (1).
- Reset (rst_n=0 at posedge):
  - State = IDLE; shift register, bit counter and q = 0.
  - valid, busy, frame_err and ovf = 0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-frame discards the partial word; a pending valid word is also cleared.
- FSM states: IDLE, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE: en=1 and data=0 -> DATA, bit counter = 0. data=1 -> stay in IDLE.
  - DATA: on en=1, shift data into position cnt, cnt+1. When cnt = N-1 is written -> STOP.
  - STOP: on en=1:
    - data=1 -> word complete, go to IDLE.
    - data=0 -> frame_err=1 for one cycle, word discarded, go to IDLE. A 0 seen here is not treated as a new start bit.
- en=0 holds the FSM, counter and shift register in every state. The handshake still operates while en=0.
- busy = 1 in every state except IDLE (registered, tracks state).
- Output register:
  - Separate from the shift register, so a new frame can be received while valid=1.
  - On word completion, the registered update takes effect the next cycle:
    - valid=0: q <= word, valid <= 1.
    - valid=1 and ready=1: q <= new word, valid stays 1 (back-to-back transfer).
    - valid=1 and ready=0: new word dropped, q unchanged, ovf=1 for one cycle.
  - No completion this cycle: valid=1 and ready=1 -> valid <= 0, q holds its value.
  - ready while valid=0 is ignored.
- Latency: start bit sampled at en-cycle 0, data at en-cycles 1..N, stop at en-cycle N+1. valid rises on the posedge after the stop sample; minimum N+2 clocks from start sample to valid.
- frame_err and ovf are never both 1 in the same cycle.

Optional Feature:
- Macro: DESER_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the N data bits; FSM path is DATA -> PARITY -> STOP.
  - Extra output perr (1 bit, reset 0) pulses for one cycle at the stop-bit cycle when the XOR of the data and parity bits is 1.
  - On a parity error the word is discarded (no valid, no ovf); frame_err still applies independently.
  - Latency grows by 1 en-cycle.
- Undefined: no PARITY state and no perr port; frame is start + N + stop.

Test Plan (all with N=4 unless noted):
- Basic receive: en=1 constant; serial 0,1,0,1,1,1 (start, 1,0,1,1, stop) -> q=4'b1101, valid=1 six clocks after the start sample; ready=1 next cycle -> valid=0.
- Gapped strobe: same frame with en toggling 1,0 -> identical q=4'b1101; valid appears after 6 en-high cycles; busy=1 throughout.
- Framing error: start, 1,1,1,1, stop=0 -> frame_err pulses one cycle, valid stays 0, FSM back in IDLE, busy=0.
- Overflow: receive 4'b0011 and hold ready=0, then receive 4'b1000 -> ovf one-cycle pulse, q stays 4'b0011; then ready=1 with a third frame 4'b0110 completing the same cycle -> q=4'b0110, valid stays 1.
- Reset mid-frame: rst_n=0 after 2 data bits, with a prior word pending (valid=1) -> next clock all outputs 0; a fresh frame 4'b1010 afterwards is received correctly.
- With DESER_RX_PARITY_EN: data 4'b0111 with parity 1 -> valid, q=4'b0111; the same frame with parity 0 -> perr pulse, no valid.

Source files
------------

// File: rtl/deser_rx.sv
// Serial-in / parallel-out frame receiver: start(0), N data bits LSB first, stop(1).
// Latency: valid rises N+2 enabled bits after the start sample (N+3 with parity).
// Backpressure: one-word output register; a word completing while valid=1 and ready=0 is dropped with ovf.
// Optional build macro: DESER_RX_PARITY_EN adds an even-parity bit before stop and the perr output.
module deser_rx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         data,
  input  logic         ready,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         busy,
  output logic         frame_err,
`ifdef DESER_RX_PARITY_EN
  output logic         perr,
`endif
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef DESER_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  word_q;
  logic          par_q, par_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;
  logic          valid_q, busy_q, ovf_q;

  // Frame FSM: advances only on strobed bits; flags completion/errors at the stop sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (!data) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = data;
          cnt_d          = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
`ifdef DESER_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef DESER_RX_PARITY_EN
        PARITY: begin
          par_d   = data;
          state_d = STOP;
        end
`endif
        STOP: begin
          // A 0 here is a framing error, never a new start bit.
          state_d = IDLE;
          ferr_d  = ~data;
`ifdef DESER_RX_PARITY_EN
          perr_d  = ^{shift_q, par_q};
`endif
          done_d  = data & ~perr_d;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, counter, shift register and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Output register: loads the completed word the cycle after the stop sample.
  // shift_q is stable then because the FSM sits in IDLE/first-start and writes no data bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || ready) begin
          word_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign q         = word_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign ovf       = ovf_q;
`ifdef DESER_RX_PARITY_EN
  assign perr      = perr_q;
`else
  logic unused_par;
  assign unused_par = par_q ^ perr_q;
`endif

endmodule
